// File: rtl/otter_sseg_scanner.sv
// OTTER IOBUS seven-segment scan controller: double-buffered 16-bit hex value, 4-digit time multiplexing.
// Optional build macro SSEG_LZ_SUPPRESS_EN blanks leading-zero digits above the most-significant nonzero nibble.
module otter_sseg_scanner #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter logic [31:0] DATA_ADDR = 32'h1100C00C,
  parameter logic [31:0] CTRL_ADDR = 32'h1100C010
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_addr,
  input  logic [31:0] IOBUS_out,
  input  logic        IOBUS_wr,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  output logic [7:0]  segs,
  output logic [3:0]  an
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(SCAN_DIV - 1);

  // Active-low a..g pattern for one hex nibble; b and d are lowercase glyphs.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [15:0]   shadow, shadow_n, active, active_n;
  logic          en, en_n, pending, pending_n;
  logic [3:0]    blank, blank_n, dp, dp_n;
  logic [PW-1:0] presc, presc_n;
  logic [1:0]    idx, idx_n;
  logic [7:0]    segs_n;
  logic [3:0]    an_n;
  logic          data_we, ctrl_we, tick;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{IOBUS_out[31:16], IOBUS_out[3:1]};

  assign data_we = IOBUS_wr && (IOBUS_addr == DATA_ADDR);
  assign ctrl_we = IOBUS_wr && (IOBUS_addr == CTRL_ADDR);
  assign tick    = (presc == DIV_LAST);

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    if (IOBUS_addr == DATA_ADDR) begin
      rd_hit  = 1'b1;
      rd_data = {16'b0, shadow};
    end else if (IOBUS_addr == CTRL_ADDR) begin
      rd_hit  = 1'b1;
      rd_data = {pending, 19'b0, dp, blank, 3'b0, en};
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    shadow_n  = shadow;
    active_n  = active;
    en_n      = en;
    blank_n   = blank;
    dp_n      = dp;
    pending_n = pending;
    presc_n   = presc;
    idx_n     = idx;

    if (ctrl_we) begin
      en_n    = IOBUS_out[0];
      blank_n = IOBUS_out[7:4];
      dp_n    = IOBUS_out[11:8];
    end

    if (!en) begin
      // While disabled the display tracks shadow directly, so enabling shows current data at once.
      presc_n   = '0;
      idx_n     = 2'd0;
      active_n  = shadow;
      pending_n = 1'b0;
    end else if (!en_n) begin
      presc_n = '0;
      idx_n   = 2'd0;
    end else if (tick) begin
      presc_n = '0;
      idx_n   = idx + 2'd1;
      if (idx == 2'd3) begin
        active_n  = shadow;
        pending_n = 1'b0;
      end
    end else begin
      presc_n = presc + PW'(1);
    end

    // A write landing on a frame-load edge keeps pending set so it shows next frame.
    if (data_we) begin
      shadow_n  = IOBUS_out[15:0];
      pending_n = 1'b1;
    end
  end

  logic [3:0] nib;
  logic       suppress;
  logic [1:0] msd;

  always_comb begin
    nib = active_n[{idx_n, 2'b00} +: 4];
    msd = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (active_n[4*i +: 4] != 4'h0) msd = 2'(i);
    end
`ifdef SSEG_LZ_SUPPRESS_EN
    suppress = (idx_n > msd);
`else
    suppress = 1'b0;
`endif
    if (!en_n || blank_n[idx_n] || suppress) begin
      segs_n = 8'hFF;
      an_n   = 4'hF;
    end else begin
      segs_n = {~dp_n[idx_n], hex7(nib)};
      an_n   = ~(4'b0001 << idx_n);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      shadow  <= '0;
      active  <= '0;
      en      <= 1'b0;
      blank   <= '0;
      dp      <= '0;
      pending <= 1'b0;
      presc   <= '0;
      idx     <= 2'd0;
      segs    <= 8'hFF;
      an      <= 4'hF;
    end else begin
      shadow  <= shadow_n;
      active  <= active_n;
      en      <= en_n;
      blank   <= blank_n;
      dp      <= dp_n;
      pending <= pending_n;
      presc   <= presc_n;
      idx     <= idx_n;
      segs    <= segs_n;
      an      <= an_n;
    end
  end

endmodule

// File: tb/tb_otter_sseg_scanner.sv
// Directed bench for otter_sseg_scanner at SCAN_DIV=4; expectations adapt to SSEG_LZ_SUPPRESS_EN.
module tb_otter_sseg_scanner;

  localparam int unsigned DIV = 4;
  localparam logic [31:0] DATA_A = 32'h1100C00C;
  localparam logic [31:0] CTRL_A = 32'h1100C010;

  logic        clk = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] IOBUS_addr = '0;
  logic [31:0] IOBUS_out = '0;
  logic        IOBUS_wr = 1'b0;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic [7:0]  segs;
  logic [3:0]  an;

  int n_checks = 0;
  int n_errors = 0;
  int pos = 0;

  otter_sseg_scanner #(.SCAN_DIV(DIV), .DATA_ADDR(DATA_A), .CTRL_ADDR(CTRL_A)) dut (
    .clk(clk), .RST_N(RST_N), .IOBUS_addr(IOBUS_addr), .IOBUS_out(IOBUS_out),
    .IOBUS_wr(IOBUS_wr), .rd_data(rd_data), .rd_hit(rd_hit), .segs(segs), .an(an)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] data;
    logic [31:0] exp_segs;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    IOBUS_addr = a;
    IOBUS_out  = d;
    IOBUS_wr   = 1'b1;
    @(negedge clk);
    IOBUS_wr   = 1'b0;
    IOBUS_addr = '0;
    pos++;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    IOBUS_addr = a;
    #1;
    check(name, rd_data, exp);
    IOBUS_addr = '0;
  endtask

  task automatic scan_check(input string tag, input logic [31:0] exp_segs,
                            input logic [3:0] bmask, input int cycles);
    int slot;
    logic [7:0] es;
    logic [3:0] ea;
    for (int i = 0; i < cycles; i++) begin
      slot = (pos / DIV) % 4;
      if (bmask[slot]) begin
        es = 8'hFF;
        ea = 4'hF;
      end else begin
        es = exp_segs[slot*8 +: 8];
        ea = ~(4'b0001 << slot);
      end
      check($sformatf("%s an pos%0d", tag, pos), 32'(an), 32'(ea));
      check($sformatf("%s segs pos%0d", tag, pos), 32'(segs), 32'(es));
      @(negedge clk);
      pos++;
    end
  endtask

  // Disable, load DATA, re-enable with ctrl; returns at the first cycle of digit 0.
  task automatic start_scan(input logic [15:0] data, input logic [31:0] ctrl);
    bus_write(CTRL_A, 32'h0);
    bus_write(DATA_A, {16'h0, data});
    bus_write(CTRL_A, ctrl);
    pos = 0;
  endtask

  vec_t vecs[5];
  logic [3:0] lz_mask_0042, lz_mask_zero;

  initial begin
    vecs[0] = '{16'h1A3F, 32'hF988B08E};
    vecs[1] = '{16'h89BC, 32'h809083C6};
    vecs[2] = '{16'h7D56, 32'hF8A19282};
    vecs[3] = '{16'hE4F0, 32'h86998EC0};
    vecs[4] = '{16'h2222, 32'hA4A4A4A4};
`ifdef SSEG_LZ_SUPPRESS_EN
    lz_mask_0042 = 4'b1100;
    lz_mask_zero = 4'b1110;
`else
    lz_mask_0042 = 4'b0000;
    lz_mask_zero = 4'b0000;
`endif

    // Reset state and address decode.
    repeat (3) @(negedge clk);
    check("reset segs", 32'(segs), 32'hFF);
    check("reset an", 32'(an), 32'hF);
    rd_check("reset ctrl rd", CTRL_A, 32'h0);
    rd_check("reset data rd", DATA_A, 32'h0);
    RST_N = 1'b1;
    @(negedge clk);
    IOBUS_addr = CTRL_A; #1;
    check("rd_hit ctrl", 32'(rd_hit), 32'h1);
    IOBUS_addr = 32'h1100C014; #1;
    check("rd_hit other", 32'(rd_hit), 32'h0);
    check("rd_data other", rd_data, 32'h0);
    IOBUS_addr = '0;

    // Table of hex patterns across all four digits.
    for (int v = 0; v < 5; v++) begin
      start_scan(vecs[v].data, 32'h1);
      rd_check($sformatf("vec%0d data rd", v), DATA_A, {16'h0, vecs[v].data});
      rd_check($sformatf("vec%0d ctrl rd", v), CTRL_A, 32'h1);
      scan_check($sformatf("vec%0d", v), vecs[v].exp_segs, 4'b0000, 20);
    end

    // Mid-frame DATA write: old digits until the 3->0 wrap.
    start_scan(16'h1A3F, 32'h1);
    scan_check("mid pre", 32'hF988B08E, 4'b0000, 6);
    bus_write(DATA_A, 32'h2222);
    rd_check("mid pending", CTRL_A, 32'h8000_0001);
    rd_check("mid shadow", DATA_A, 32'h2222);
    scan_check("mid old", 32'hF988B08E, 4'b0000, 9);
    scan_check("mid new", 32'hA4A4A4A4, 4'b0000, 16);
    rd_check("mid pending clr", CTRL_A, 32'h1);

    // Blank digit 1, DP on digits 0 and 1.
    start_scan(16'h8888, 32'h0321);
    rd_check("dp ctrl rd", CTRL_A, 32'h0000_0321);
    scan_check("dp", 32'h8080FF00, 4'b0010, 16);

    // Leading zeros.
    start_scan(16'h0042, 32'h1);
    scan_check("lz", 32'hC0C099A4, lz_mask_0042, 16);

    // DATA write on the exact frame-load edge.
    start_scan(16'h1111, 32'h1);
    scan_check("edge pre", 32'hF9F9F9F9, 4'b0000, 15);
    bus_write(DATA_A, 32'h3333);
    rd_check("edge pending", CTRL_A, 32'h8000_0001);
    scan_check("edge old", 32'hF9F9F9F9, 4'b0000, 16);
    scan_check("edge new", 32'hB0B0B0B0, 4'b0000, 16);

    // en 1->0 blanks on the next edge.
    bus_write(CTRL_A, 32'h0);
    check("dis segs", 32'(segs), 32'hFF);
    check("dis an", 32'(an), 32'hF);

    // Unused CTRL bits ignored; all digits blanked.
    bus_write(CTRL_A, 32'hFFFF_FFFF);
    rd_check("ctrl mask rd", CTRL_A, 32'h0000_0FF1);
    check("allblank an", 32'(an), 32'hF);
    bus_write(CTRL_A, 32'h0);

    // Write to a foreign address is ignored.
    bus_write(32'h1100C014, 32'hDEAD);
    rd_check("foreign wr", DATA_A, 32'h3333);

    // Reset mid-scan.
    start_scan(16'h1A3F, 32'h1);
    scan_check("pre rst", 32'hF988B08E, 4'b0000, 6);
    #2 RST_N = 1'b0;
    #1;
    check("rst segs", 32'(segs), 32'hFF);
    check("rst an", 32'(an), 32'hF);
    rd_check("rst ctrl rd", CTRL_A, 32'h0);
    rd_check("rst data rd", DATA_A, 32'h0);
    @(negedge clk);
    RST_N = 1'b1;
    @(negedge clk);
    check("post rst an", 32'(an), 32'hF);
    bus_write(CTRL_A, 32'h1);
    pos = 0;
    scan_check("zero", 32'hC0C0C0C0, lz_mask_zero, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
